// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MEM-stage state encoding, control-field positions and helpers
package mips_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_RD = 2'd1;
  localparam logic [1:0] ST_WAIT_WR = 2'd2;

  // WB = {regWrite, memToReg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // MEM = {branch, memRead, memWrite}
  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - wait-cycle counter that flags the last allowed cycle before dmem_ack times out
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // Expires during the TIMEOUT-th wait cycle so the stage gives up on that edge.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: data-memory handshake, branch resolve and MEM/WB register
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] addPc,
  input  logic [31:0] aluResult,
  input  logic        zero,
  input  logic [31:0] readData2,
  input  logic [4:0]  muxInst,
  input  logic [1:0]  WB,
  input  logic [2:0]  MEM,
  output logic        stall,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] readDataOut,
  output logic [31:0] aluResultOut,
  output logic [4:0]  muxInstOut,
  output logic [1:0]  WBOut,
  output logic        err_timeout,
  output logic        err_misalign
);

  logic [1:0] state;
  logic       skip;
  logic [1:0] pend_wb;
  logic [4:0] pend_rd;
  logic       is_rd;
  logic       is_wr;
  logic       is_mem;
  logic       aligned;
  logic       fresh;
  logic       launch;
  logic       waiting;
  logic       expired;

  assign is_rd   = MEM[MEM_READ];
  assign is_wr   = MEM[MEM_WRITE];
  assign is_mem  = is_rd | is_wr;
  assign aligned = word_aligned(aluResult[1:0]);
  assign waiting = (state == ST_WAIT_RD) || (state == ST_WAIT_WR);

  // After a memory op retires, upstream is still presenting the bundle it held;
  // skip consumes that copy once instead of launching it a second time.
  assign fresh  = (state == ST_IDLE) && !skip && in_valid;
  assign launch = fresh && is_mem && aligned;
  assign stall  = reset_n && (waiting || launch);

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (launch),
    .enable  (waiting),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      skip         <= 1'b0;
      pend_wb      <= 2'b00;
      pend_rd      <= 5'd0;
      pcSrc        <= 1'b0;
      branchTarget <= 32'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      out_valid    <= 1'b0;
      readDataOut  <= 32'd0;
      aluResultOut <= 32'd0;
      muxInstOut   <= 5'd0;
      WBOut        <= 2'b00;
      err_timeout  <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      pcSrc     <= 1'b0;
      case (state)
        ST_IDLE: begin
          skip <= 1'b0;
          if (fresh) begin
            pcSrc        <= MEM[MEM_BRANCH] & zero;
            branchTarget <= addPc;
            if (!is_mem) begin
              out_valid    <= 1'b1;
              aluResultOut <= aluResult;
              muxInstOut   <= muxInst;
              WBOut        <= WB;
            end else if (!aligned) begin
              err_misalign <= 1'b1;
              out_valid    <= 1'b1;
              aluResultOut <= aluResult;
              muxInstOut   <= muxInst;
              WBOut        <= 2'b00;
            end else begin
              // A write wins when both memRead and memWrite are set.
              dmem_req   <= 1'b1;
              dmem_we    <= is_wr;
              dmem_addr  <= aluResult;
              dmem_wdata <= is_wr ? readData2 : 32'd0;
              pend_wb    <= WB;
              pend_rd    <= muxInst;
              state      <= is_wr ? ST_WAIT_WR : ST_WAIT_RD;
            end
          end
        end
        ST_WAIT_RD, ST_WAIT_WR: begin
          if (dmem_ack || expired) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            out_valid    <= 1'b1;
            aluResultOut <= dmem_addr;
            muxInstOut   <= pend_rd;
            WBOut        <= dmem_ack ? pend_wb : 2'b00;
            if (dmem_ack && state == ST_WAIT_RD) begin
              readDataOut <= dmem_rdata;
            end
            if (!dmem_ack) begin
              err_timeout <= 1'b1;
            end
            skip  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed vectors
module tb_mem_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] addPc;
  logic [31:0] aluResult;
  logic        zero;
  logic [31:0] readData2;
  logic [4:0]  muxInst;
  logic [1:0]  WB;
  logic [2:0]  MEM;
  logic        stall;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] readDataOut;
  logic [31:0] aluResultOut;
  logic [4:0]  muxInstOut;
  logic [1:0]  WBOut;
  logic        err_timeout;
  logic        err_misalign;

  mem_stage #(.TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .addPc(addPc),
    .aluResult(aluResult), .zero(zero), .readData2(readData2), .muxInst(muxInst),
    .WB(WB), .MEM(MEM), .stall(stall), .pcSrc(pcSrc), .branchTarget(branchTarget),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .readDataOut(readDataOut), .aluResultOut(aluResultOut),
    .muxInstOut(muxInstOut), .WBOut(WBOut), .err_timeout(err_timeout),
    .err_misalign(err_misalign)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  mux;
    logic [1:0]  wb;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int ov_count = 0;
  int push_count = 0;
  int req_cycles = 0;
  int req_run = 0;
  int ack_delay = 0;
  logic [31:0] ack_data = 32'd0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wdata = 32'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic expect_out(input logic [31:0] rd, input logic [31:0] alu,
                            input logic [4:0] mux, input logic [1:0] wb);
    exp_t e;
    e.rd = rd; e.alu = alu; e.mux = mux; e.wb = wb;
    sb.push_back(e);
    push_count++;
  endtask

  // Models an upstream that holds the bundle for as long as stall is high.
  task automatic issue(input logic [2:0] mem, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [4:0] mux, input logic z,
                       input logic [31:0] pc, output int stalls);
    logic s;
    logic done;
    int   n;
    in_valid = 1'b1; MEM = mem; WB = wb; aluResult = alu;
    readData2 = rd2; muxInst = mux; zero = z; addPc = pc;
    stalls = 0; n = 0; done = 1'b0;
    while (!done) begin
      #1 s = stall;
      @(negedge clock);
      if (!s) begin
        done = 1'b1;
      end else begin
        stalls++;
        n++;
        if (n > 40) begin
          chk("stall_bound", 32'(n), 32'd40);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Data-memory responder; also checks the request stays stable while pending.
  initial begin
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    forever begin
      @(negedge clock);
      dmem_ack = 1'b0;
      dmem_rdata = 32'h5555_5555;
      if (dmem_req) begin
        req_cycles++;
        req_run++;
        chk("hold_we", 32'(dmem_we), 32'(exp_we));
        chk("hold_addr", dmem_addr, exp_addr);
        chk("hold_wdata", dmem_wdata, exp_wdata);
        if (ack_delay != 0 && req_run == ack_delay) begin
          dmem_ack = 1'b1;
          dmem_rdata = ack_data;
        end
      end else begin
        req_run = 0;
      end
    end
  end

  // Monitor: every out_valid pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && out_valid) begin
        ov_count++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid actual=1 required=0 alu=%h", aluResultOut);
        end else begin
          e = sb.pop_front();
          chk("readDataOut", readDataOut, e.rd);
          chk("aluResultOut", aluResultOut, e.alu);
          chk("muxInstOut", 32'(muxInstOut), 32'(e.mux));
          chk("WBOut", 32'(WBOut), 32'(e.wb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int rq;
    reset_n = 1'b0; in_valid = 1'b0; addPc = 32'd0; aluResult = 32'd0; zero = 1'b0;
    readData2 = 32'd0; muxInst = 5'd0; WB = 2'b00; MEM = 3'b000;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_errs", 32'({err_timeout, err_misalign}), 32'd0);
    chk("rst_aluResultOut", aluResultOut, 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // ALU op
    expect_out(32'd0, 32'h1234, 5'd5, 2'b10);
    issue(3'b000, 2'b10, 32'h1234, 32'd0, 5'd5, 1'b0, 32'h0, st);
    chk("alu_stall", 32'(st), 32'd0);

    // Load: ack in the third request cycle
    ack_delay = 3; ack_data = 32'hDEAD_BEEF;
    exp_we = 1'b0; exp_addr = 32'h40; exp_wdata = 32'd0;
    expect_out(32'hDEAD_BEEF, 32'h40, 5'd7, 2'b11);
    issue(3'b010, 2'b11, 32'h40, 32'h0, 5'd7, 1'b0, 32'h0, st);
    chk("load_stall_cycles", 32'(st), 32'd4);

    // Store: readDataOut must keep the loaded value
    ack_delay = 2; ack_data = 32'h1111_1111;
    exp_we = 1'b1; exp_addr = 32'h80; exp_wdata = 32'hA5A5_A5A5;
    expect_out(32'hDEAD_BEEF, 32'h80, 5'd0, 2'b00);
    issue(3'b001, 2'b00, 32'h80, 32'hA5A5_A5A5, 5'd0, 1'b0, 32'h0, st);
    chk("store_stall_cycles", 32'(st), 32'd3);

    // Read+write together performs the write only
    ack_delay = 1; ack_data = 32'h2222_2222;
    exp_we = 1'b1; exp_addr = 32'h84; exp_wdata = 32'h0BAD_F00D;
    expect_out(32'hDEAD_BEEF, 32'h84, 5'd3, 2'b10);
    issue(3'b011, 2'b10, 32'h84, 32'h0BAD_F00D, 5'd3, 1'b0, 32'h0, st);

    // Branch taken then not taken
    expect_out(32'hDEAD_BEEF, 32'h10, 5'd1, 2'b00);
    issue(3'b100, 2'b00, 32'h10, 32'h0, 5'd1, 1'b1, 32'h400, st);
    chk("br_pcSrc", 32'(pcSrc), 32'd1);
    chk("br_target", branchTarget, 32'h400);
    @(negedge clock);
    chk("br_pcSrc_pulse", 32'(pcSrc), 32'd0);
    expect_out(32'hDEAD_BEEF, 32'h14, 5'd2, 2'b00);
    issue(3'b100, 2'b00, 32'h14, 32'h0, 5'd2, 1'b0, 32'h800, st);
    chk("br_nt_pcSrc", 32'(pcSrc), 32'd0);
    chk("br_nt_target", branchTarget, 32'h800);

    // Idle cycles: outputs hold, no pulses
    repeat (3) @(negedge clock);
    chk("idle_aluResultOut", aluResultOut, 32'h14);

    // Misaligned load: no request, WB squashed
    rq = req_cycles;
    expect_out(32'hDEAD_BEEF, 32'h42, 5'd9, 2'b00);
    issue(3'b010, 2'b11, 32'h42, 32'h0, 5'd9, 1'b0, 32'h0, st);
    chk("mis_stall", 32'(st), 32'd0);
    chk("mis_err", 32'(err_misalign), 32'd1);
    chk("mis_no_req", 32'(req_cycles - rq), 32'd0);

    // Timeout: ack never comes, gives up after 4 wait cycles
    ack_delay = 0;
    exp_we = 1'b0; exp_addr = 32'h44; exp_wdata = 32'd0;
    rq = req_cycles;
    expect_out(32'hDEAD_BEEF, 32'h44, 5'd4, 2'b00);
    issue(3'b010, 2'b11, 32'h44, 32'h0, 5'd4, 1'b0, 32'h0, st);
    chk("to_stall_cycles", 32'(st), 32'd5);
    chk("to_req_cycles", 32'(req_cycles - rq), 32'd4);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_mis_sticky", 32'(err_misalign), 32'd1);

    // Reset during WAIT_RD
    exp_we = 1'b0; exp_addr = 32'h48; exp_wdata = 32'd0;
    in_valid = 1'b1; MEM = 3'b010; WB = 2'b11; aluResult = 32'h48; muxInst = 5'd6;
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    chk("rr_req_before", 32'(dmem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rr_req_dropped", 32'(dmem_req), 32'd0);
    chk("rr_state", 32'(dut.state), 32'd0);
    chk("rr_stall", 32'(stall), 32'd0);
    chk("rr_errs", 32'({err_timeout, err_misalign}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Stage works again after reset
    expect_out(32'd0, 32'hCAFE, 5'd8, 2'b10);
    issue(3'b000, 2'b10, 32'hCAFE, 32'h0, 5'd8, 1'b0, 32'h0, st);
    repeat (2) @(negedge clock);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("pulse_count", 32'(ov_count), 32'(push_count));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all state updates on posedge.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid in 1; addPc in 32; aluResult in 32; zero in 1; readData2 in 32; muxInst in 5; WB in 2 {regWrite,memToReg}; MEM in 3 {branch,memRead,memWrite}. Together these are the EXE/MEM bundle.
REQ-004 SHALL have port: stall  out  1  high: upstream holds the EXE/MEM bundle.
REQ-005 SHALL have ports: pcSrc out 1 (branch taken); branchTarget out 32.
REQ-006 SHALL have ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_ack in 1; dmem_rdata in 32.
REQ-007 SHALL have ports: out_valid out 1; readDataOut out 32; aluResultOut out 32; muxInstOut out 5; WBOut out 2. These form the MEM/WB bundle.
REQ-008 SHALL have ports: err_timeout out 1 and err_misalign out 1, both sticky.
REQ-009 SHALL have parameter: TIMEOUT, default 255, meaning the maximum number of cycles to wait for dmem_ack.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_RD, WAIT_WR.
REQ-011 In IDLE, with in_valid=1 and no memory op, SHALL register the MEM/WB bundle and set out_valid=1 on the next edge (latency 1).
REQ-012 In IDLE, with in_valid=1, memRead=1 and aluResult[1:0]==0, SHALL assert dmem_req with dmem_we=0 and dmem_addr=aluResult, and go to WAIT_RD.
REQ-013 In IDLE, with in_valid=1, memWrite=1 and an aligned address, SHALL assert dmem_req with dmem_we=1 and dmem_wdata=readData2, and go to WAIT_WR.
REQ-014 If memRead and memWrite are both 1, SHALL perform the write only.
REQ-015 dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL be registered and held stable until the dmem_ack cycle. They SHALL deassert on the edge after the ack.
REQ-016 stall SHALL be high in WAIT_RD and WAIT_WR, and also in the IDLE cycle that launches a request. It SHALL be low otherwise.
REQ-017 On dmem_ack in WAIT_RD, SHALL capture dmem_rdata into readDataOut, pulse out_valid, and return to IDLE.
REQ-018 On dmem_ack in WAIT_WR, SHALL pulse out_valid and return to IDLE. readDataOut SHALL be left unchanged.
REQ-019 dmem_ack while in IDLE SHALL be ignored.
REQ-020 A wait counter SHALL clear on request launch and increment each wait cycle. On reaching TIMEOUT without ack: set err_timeout, drop dmem_req, pulse out_valid with WBOut=00, and return to IDLE.
REQ-021 A misaligned memory op SHALL issue no request, SHALL set err_misalign, and SHALL emit out_valid with WBOut=00 after 1 cycle.
REQ-022 pcSrc SHALL be a registered 1-cycle pulse equal to in_valid & branch & zero, sampled in IDLE. branchTarget SHALL register addPc in the same cycle.
REQ-023 out_valid SHALL be a single-cycle pulse per accepted bundle. The bundle SHALL be accepted only in IDLE with stall low at that edge.
REQ-024 With in_valid=0 in IDLE, SHALL hold out_valid=0 and leave the data outputs unchanged.

Reset
REQ-025 With reset_n=0, SHALL asynchronously force: state=IDLE, counter=0, and every output to 0, including both error flags.
REQ-026 Reset mid-transaction SHALL drop dmem_req immediately, and SHALL NOT emit out_valid for the aborted op.
REQ-027 Error flags SHALL clear only by reset.

Structure
REQ-028 The FSM state encoding and the bit positions of the WB and MEM fields SHALL be defined in a shared package, mips_pkg.
REQ-029 The timeout counter SHALL be a sub-module, mem_timeout_ctr, with ports clear, enable and expired.
REQ-030 The block SHALL contain no other sub-modules and no memory arrays.

Verification
REQ-031 Scenario ALU op: in_valid=1, MEM=000, WB=10, aluResult=0x1234. Required: next cycle out_valid=1, aluResultOut=0x1234, WBOut=10, stall=0.
REQ-032 Scenario load: MEM=010, aluResult=0x40, dmem_ack 3 cycles after dmem_req, dmem_rdata=0xDEADBEEF. Required: stall high for 4 cycles, readDataOut=0xDEADBEEF, one out_valid pulse.
REQ-033 Scenario store: MEM=001, readData2=0xA5A5A5A5, addr=0x80. Required: dmem_we=1 and dmem_wdata held until ack; out_valid with readDataOut unchanged.
REQ-034 Scenario branch: MEM=100, zero=1, addPc=0x400. Required: pcSrc pulses 1 cycle, branchTarget=0x400. With zero=0: pcSrc stays 0.
REQ-035 Scenario faults: addr=0x42 load gives err_misalign=1, no dmem_req, WBOut=00. TIMEOUT=4 with ack never sent gives err_timeout=1 after 4 wait cycles.
REQ-036 Scenario reset: reset_n low during WAIT_RD. Required: dmem_req=0 immediately, state=IDLE, no out_valid.
